// File: rtl/cfg_shift_receiver.sv
// cfg_shift_receiver: MSB-first serial config receiver feeding dynamic/static latch banks.
// Define SHREG_PARITY_EN to require an even-parity bit after the payload.
module cfg_shift_receiver #(
  parameter int DYN_W  = 16,
  parameter int STAT_W = 88
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              SDI,
  input  logic              SEN,
  input  logic              SLD,
  output logic [DYN_W-1:0]  DYNLATCH,
  output logic [STAT_W-1:0] STATLATCH,
  output logic              ENFIN,
  output logic              FRAME_ERR,
  output logic              SDO
);

  localparam int CW = $clog2(STAT_W + 1);
  localparam logic [CW-1:0] DYN_LAST  = CW'(DYN_W - 1);
  localparam logic [CW-1:0] STAT_LAST = CW'(STAT_W - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    PARITY,
    WAIT_LD
  } state_t;

  state_t              state_q, state_d;
  logic [STAT_W-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                sel_q, sel_d;
  logic                sdo_d;
  logic [DYN_W-1:0]    dyn_d;
  logic [STAT_W-1:0]   stat_d;
  logic                enfin_d;
  logic                err_d;
  logic                last;
`ifdef SHREG_PARITY_EN
  logic                par_q, par_d;
`endif

  assign last = (cnt_q == (sel_q ? STAT_LAST : DYN_LAST));

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    sdo_d   = SDO;
    dyn_d   = DYNLATCH;
    stat_d  = STATLATCH;
    enfin_d = 1'b0;
    err_d   = 1'b0;
`ifdef SHREG_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (SEN) begin
          sel_d   = SDI;
          cnt_d   = '0;
          state_d = PAYLOAD;
`ifdef SHREG_PARITY_EN
          par_d   = SDI;
`endif
        end
      end
      PAYLOAD: begin
        if (!SEN || SLD) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          sdo_d   = shreg_q[STAT_W-1];
          shreg_d = {shreg_q[STAT_W-2:0], SDI};
          cnt_d   = cnt_q + CNT_ONE;
`ifdef SHREG_PARITY_EN
          par_d   = par_q ^ SDI;
          if (last) state_d = PARITY;
`else
          if (last) state_d = WAIT_LD;
`endif
        end
      end
      PARITY: begin
`ifdef SHREG_PARITY_EN
        // Running parity covers header and payload; the bit must match it.
        if (!SEN || SLD || (SDI != par_q)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT_LD;
        end
`else
        state_d = IDLE;
`endif
      end
      WAIT_LD: begin
        if (SEN) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (SLD) begin
          if (sel_q) stat_d = shreg_q;
          else       dyn_d  = shreg_q[DYN_W-1:0];
          enfin_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      sel_q     <= 1'b0;
      SDO       <= 1'b0;
      DYNLATCH  <= '0;
      STATLATCH <= '0;
      ENFIN     <= 1'b0;
      FRAME_ERR <= 1'b0;
`ifdef SHREG_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      SDO       <= sdo_d;
      DYNLATCH  <= dyn_d;
      STATLATCH <= stat_d;
      ENFIN     <= enfin_d;
      FRAME_ERR <= err_d;
`ifdef SHREG_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_cfg_shift_receiver.sv
// tb_cfg_shift_receiver: directed frames with a scoreboard of expected ENFIN/FRAME_ERR events.
// Honours SHREG_PARITY_EN when defined.
module tb_cfg_shift_receiver;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        SDI;
  logic        SEN;
  logic        SLD;
  logic [15:0] DYNLATCH;
  logic [87:0] STATLATCH;
  logic        ENFIN;
  logic        FRAME_ERR;
  logic        SDO;

  always #5 CLK = ~CLK;

  cfg_shift_receiver #(.DYN_W(16), .STAT_W(88)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .SDI       (SDI),
    .SEN       (SEN),
    .SLD       (SLD),
    .DYNLATCH  (DYNLATCH),
    .STATLATCH (STATLATCH),
    .ENFIN     (ENFIN),
    .FRAME_ERR (FRAME_ERR),
    .SDO       (SDO)
  );

  typedef struct packed {
    logic        enfin;
    logic        err;
    logic [15:0] dyn;
    logic [87:0] stat;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_dyn;
  logic [87:0] exp_stat;
  logic [15:0] sdo_w;

  localparam logic [87:0] STAT_V = 88'hDEADBEEF_01234567_89ABCD;

  task automatic check(input string name, input logic [87:0] act,
                       input logic [87:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  always @(negedge CLK) begin
    if (RST_N === 1'b1 && (ENFIN !== 1'b0 || FRAME_ERR !== 1'b0)) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: enfin=%b frame_err=%b want none",
                 ENFIN, FRAME_ERR);
      end else begin
        mon_e = sbq.pop_front();
        check("enfin", 88'(ENFIN), 88'(mon_e.enfin));
        check("frame_err", 88'(FRAME_ERR), 88'(mon_e.err));
        check("dynlatch", 88'(DYNLATCH), 88'(mon_e.dyn));
        check("statlatch", STATLATCH, mon_e.stat);
      end
    end
  end

  task automatic drive(input logic sen, input logic sdi, input logic sld);
    @(negedge CLK);
    SEN = sen;
    SDI = sdi;
    SLD = sld;
  endtask

  task automatic frame(input logic hdr, input int w,
                       input logic [87:0] val, input int nbits);
    drive(1'b1, hdr, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      drive(1'b1, val[w-1-i], 1'b0);
      @(posedge CLK);
      #1 sdo_w = {sdo_w[14:0], SDO};
    end
  endtask

`ifdef SHREG_PARITY_EN
  function automatic logic par(input logic hdr, input int w,
                               input logic [87:0] val);
    logic p;
    p = hdr;
    for (int i = 0; i < w; i++) p ^= val[i];
    return p;
  endfunction
`endif

  task automatic parity(input logic hdr, input int w,
                        input logic [87:0] val, input logic flip);
`ifdef SHREG_PARITY_EN
    drive(1'b1, par(hdr, w, val) ^ flip, 1'b0);
`else
    if (flip && hdr && (w < 0) && val[0]) $display("unused");
`endif
  endtask

  task automatic load(input logic hdr, input logic [87:0] val);
    if (hdr) exp_stat = val;
    else     exp_dyn  = val[15:0];
    sbq.push_back('{1'b1, 1'b0, exp_dyn, exp_stat});
    drive(1'b0, 1'b0, 1'b1);
  endtask

  task automatic abort(input logic sen, input logic sdi, input logic sld);
    sbq.push_back('{1'b0, 1'b1, exp_dyn, exp_stat});
    drive(sen, sdi, sld);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_dyn"}, 88'(DYNLATCH), '0);
    check({tag, "_stat"}, STATLATCH, '0);
    check({tag, "_enfin"}, 88'(ENFIN), '0);
    check({tag, "_err"}, 88'(FRAME_ERR), '0);
    check({tag, "_sdo"}, 88'(SDO), '0);
  endtask

  initial begin
    RST_N    = 1'b0;
    SEN      = 1'b0;
    SDI      = 1'b0;
    SLD      = 1'b0;
    exp_dyn  = '0;
    exp_stat = '0;
    sdo_w    = '0;
    repeat (2) @(negedge CLK);
    #1 check_zero("reset");
    @(negedge CLK);
    RST_N = 1'b1;

    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);

    frame(1'b0, 16, 88'h0000A5C3, 16);
    parity(1'b0, 16, 88'h0000A5C3, 1'b0);
    load(1'b0, 88'h0000A5C3);
    drive(1'b0, 1'b0, 1'b0);

    frame(1'b1, 88, STAT_V, 88);
    parity(1'b1, 88, STAT_V, 1'b0);
    load(1'b1, STAT_V);
    frame(1'b0, 16, 88'h00000001, 16);
    check("sdo_echo", 88'(sdo_w), 88'h0DEAD);
    parity(1'b0, 16, 88'h00000001, 1'b0);
    load(1'b0, 88'h00000001);
    drive(1'b0, 1'b0, 1'b0);

    frame(1'b0, 16, 88'h0000FFFF, 10);
    abort(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);

    frame(1'b1, 88, 88'h123456789ABCDEF0123456, 39);
    abort(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0);

    frame(1'b0, 16, 88'h0000BEEF, 16);
    parity(1'b0, 16, 88'h0000BEEF, 1'b0);
    abort(1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);

    frame(1'b1, 88, 88'hFFFFFFFFFFFFFFFFFFFFFF, 50);
    @(negedge CLK);
    RST_N = 1'b0;
    SEN   = 1'b0;
    SDI   = 1'b0;
    SLD   = 1'b0;
    #1 check_zero("midreset");
    exp_dyn  = '0;
    exp_stat = '0;
    @(negedge CLK);
    RST_N = 1'b1;
    frame(1'b0, 16, 88'h00001234, 16);
    parity(1'b0, 16, 88'h00001234, 1'b0);
    load(1'b0, 88'h00001234);
    drive(1'b0, 1'b0, 1'b0);

`ifdef SHREG_PARITY_EN
    frame(1'b0, 16, 88'h000000FF, 16);
    sbq.push_back('{1'b0, 1'b1, exp_dyn, exp_stat});
    parity(1'b0, 16, 88'h000000FF, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    frame(1'b0, 16, 88'h000000FF, 16);
    parity(1'b0, 16, 88'h000000FF, 1'b0);
    load(1'b0, 88'h000000FF);
    drive(1'b0, 1'b0, 1'b0);
`endif

    repeat (4) drive(1'b0, 1'b0, 1'b0);
    check("sb_drained", 88'(sbq.size()), '0);
    check("final_dyn", 88'(DYNLATCH), 88'(exp_dyn));
    check("final_stat", STATLATCH, exp_stat);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
